execute_muldiv: RTL and testbench

Iterative RV32M multiply/divide unit in the execute stage. It consumes the operands and `funct3E` that the decode/execute pipeline register produces, and computes all eight M-extension operations over multiple cycles. While it works, it asserts `BusyE`, which the hazard unit ORs into `StallF`/`StallD`/`StallE` so the instruction stays in execute. Its result is muxed into the ALU-result path ahead of the execute/memory register.

---
 rtl/execute_muldiv.sv | 158 +++++++++++++++
 tb/tb_execute_muldiv.sv | 133 +++++++++++++
 2 files changed

// File: rtl/execute_muldiv.sv
// Iterative RV32M multiply/divide unit for the execute stage.
// Shift-add multiply and restoring divide, one bit per cycle, with a stall request to the hazard unit.
module execute_muldiv #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  StartE,
  input  logic                  AbortE,
  input  logic [2:0]            funct3E,
  input  logic [DATA_WIDTH-1:0] SrcAE,
  input  logic [DATA_WIDTH-1:0] SrcBE,
  output logic                  BusyE,
  output logic                  DoneE,
  output logic [DATA_WIDTH-1:0] ResultE
);
  localparam int W = DATA_WIDTH;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  localparam logic [2:0] F_MUL    = 3'b000;
  localparam logic [2:0] F_MULH   = 3'b001;
  localparam logic [2:0] F_MULHSU = 3'b010;
  localparam logic [2:0] F_DIV    = 3'b100;
  localparam logic [2:0] F_REM    = 3'b110;

  state_t         state_q, state_d;
  logic [4:0]     cnt_q, cnt_d;
  logic [2:0]     op_q, op_d;
  logic           neg_q, neg_d;
  logic [W-1:0]   a_q, a_d;        // multiplicand for mul, divisor for div
  logic [2*W-1:0] acc_q, acc_d;    // product accumulator / low half holds dividend->quotient
  logic [W:0]     rem_q, rem_d;
  logic           done_q, done_d;
  logic [W-1:0]   result_q, result_d;

  // Operand decode at start
  logic           sign_a, sign_b, is_sdiv, div_zero, div_ovf, start_neg;
  logic [W-1:0]   mag_a, mag_b;
  localparam logic [W-1:0] INT_MIN = {1'b1, {(W-1){1'b0}}};

  always_comb begin
    is_sdiv   = (funct3E == F_DIV) || (funct3E == F_REM);
    sign_a    = SrcAE[W-1] && (funct3E == F_MULH || funct3E == F_MULHSU || is_sdiv);
    sign_b    = SrcBE[W-1] && (funct3E == F_MULH || is_sdiv);
    mag_a     = sign_a ? -SrcAE : SrcAE;
    mag_b     = sign_b ? -SrcBE : SrcBE;
    start_neg = (funct3E == F_REM) ? sign_a : (sign_a ^ sign_b);
    div_zero  = funct3E[2] && (SrcBE == '0);
    div_ovf   = is_sdiv && (SrcAE == INT_MIN) && (SrcBE == '1);
  end

  // One iteration of each datapath
  logic [W:0]     mul_sum, div_sh, div_diff, rem_nxt;
  logic [2*W-1:0] mul_nxt, prod;
  logic [W-1:0]   quo_nxt, q_res, r_res, mul_res, div_res;
  logic           div_ge;

  always_comb begin
    mul_sum  = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, a_q} : '0);
    mul_nxt  = {mul_sum, acc_q[W-1:1]};
    div_sh   = {rem_q[W-1:0], acc_q[W-1]};
    div_diff = div_sh - {1'b0, a_q};
    div_ge   = (div_sh >= {1'b0, a_q});
    rem_nxt  = div_ge ? div_diff : div_sh;
    quo_nxt  = {acc_q[W-2:0], div_ge};
    prod     = neg_q ? -mul_nxt : mul_nxt;
    mul_res  = (op_q == F_MUL) ? prod[W-1:0] : prod[2*W-1:W];
    q_res    = neg_q ? -quo_nxt : quo_nxt;
    r_res    = neg_q ? -rem_nxt[W-1:0] : rem_nxt[W-1:0];
    div_res  = op_q[1] ? r_res : q_res;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    neg_d    = neg_q;
    a_d      = a_q;
    acc_d    = acc_q;
    rem_d    = rem_q;
    done_d   = 1'b0;
    result_d = result_q;
    case (state_q)
      IDLE: begin
        if (StartE && !AbortE) begin
          op_d  = funct3E;
          neg_d = start_neg;
          if (div_zero) begin
            result_d = funct3E[1] ? SrcAE : '1;
            done_d   = 1'b1;
            state_d  = DONE;
          end else if (div_ovf) begin
            result_d = funct3E[1] ? '0 : INT_MIN;
            done_d   = 1'b1;
            state_d  = DONE;
          end else begin
            a_d     = funct3E[2] ? mag_b : mag_a;
            acc_d   = {{W{1'b0}}, funct3E[2] ? mag_a : mag_b};
            rem_d   = '0;
            cnt_d   = 5'd31;
            state_d = CALC;
          end
        end
      end
      CALC: begin
        if (op_q[2]) begin
          acc_d = {acc_q[2*W-1:W], quo_nxt};
          rem_d = rem_nxt;
        end else begin
          acc_d = mul_nxt;
        end
        cnt_d = cnt_q - 5'd1;
        if (cnt_q == 5'd0) begin
          result_d = op_q[2] ? div_res : mul_res;
          done_d   = 1'b1;
          state_d  = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
    // A killed instruction leaves the last committed result visible
    if (AbortE) begin
      state_d  = IDLE;
      done_d   = 1'b0;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      neg_q    <= 1'b0;
      a_q      <= '0;
      acc_q    <= '0;
      rem_q    <= '0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      neg_q    <= neg_d;
      a_q      <= a_d;
      acc_q    <= acc_d;
      rem_q    <= rem_d;
      done_q   <= done_d;
      result_q <= result_d;
    end
  end

  assign BusyE   = !rst && !AbortE &&
                   (((state_q == IDLE) && StartE) || (state_q == CALC));
  assign DoneE   = done_q;
  assign ResultE = result_q;
endmodule

// File: tb/tb_execute_muldiv.sv
// Directed bench for execute_muldiv: driver pushes expected results, a monitor
// compares them whenever DoneE pulses.
module tb_execute_muldiv;
  logic        clk = 1'b0;
  logic        rst;
  logic        StartE, AbortE;
  logic [2:0]  funct3E;
  logic [31:0] SrcAE, SrcBE;
  logic        BusyE, DoneE;
  logic [31:0] ResultE;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] exp_q[$];
  string       name_q[$];

  execute_muldiv #(.DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .StartE(StartE), .AbortE(AbortE), .funct3E(funct3E),
    .SrcAE(SrcAE), .SrcBE(SrcBE), .BusyE(BusyE), .DoneE(DoneE), .ResultE(ResultE)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: every DoneE pulse must match the oldest outstanding expectation
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && DoneE === 1'b1) begin
        if (exp_q.size() == 0) check("unexpected DoneE", {31'b0, DoneE}, 32'd0);
        else check(name_q.pop_front(), ResultE, exp_q.pop_front());
      end
    end
  end

  task automatic run_op(input string nm, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int exp_busy);
    int cnt;
    @(negedge clk);
    funct3E = f; SrcAE = a; SrcBE = b; StartE = 1'b1;
    exp_q.push_back(exp);
    name_q.push_back(nm);
    #1;
    cnt = 0;
    while (BusyE && cnt < 100) begin
      cnt++;
      @(negedge clk);
      #1;
      if (cnt == 3) begin SrcAE = SrcAE ^ 32'h5a5a_1234; SrcBE = ~SrcBE; end
    end
    StartE = 1'b0;
    check({nm, " busy cycles"}, cnt, exp_busy);
  endtask

  initial begin
    rst = 1'b1; StartE = 1'b1; AbortE = 1'b0; funct3E = 3'b000;
    SrcAE = 32'd7; SrcBE = 32'd9;
    repeat (2) @(negedge clk);
    #1;
    check("reset BusyE", {31'b0, BusyE}, 32'd0);
    check("reset DoneE", {31'b0, DoneE}, 32'd0);
    check("reset ResultE", ResultE, 32'd0);
    @(negedge clk);
    rst = 1'b0; StartE = 1'b0;

    run_op("MUL 7*-3", 3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33);
    @(negedge clk); #1;
    check("MUL DoneE after pulse", {31'b0, DoneE}, 32'd0);
    check("MUL ResultE held", ResultE, 32'hFFFF_FFEB);

    run_op("MULH min*min",   3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33);
    run_op("MULHU min*min",  3'b011, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33);
    run_op("MULHSU -1*ffff", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33);
    run_op("DIVU 100/7",     3'b101, 32'd100, 32'd7, 32'd14, 33);
    run_op("REMU 100/7",     3'b111, 32'd100, 32'd7, 32'd2, 33);
    run_op("DIV -100/7",     3'b100, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 33);
    run_op("REM -100/7",     3'b110, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE, 33);
    run_op("DIV 5/0",        3'b100, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
    run_op("REMU 5/0",       3'b111, 32'd5, 32'd0, 32'd5, 1);
    run_op("DIV ovf",        3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    run_op("REM ovf",        3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);

    // Reset while a DIVU sits at counter 15; its result must never appear
    @(negedge clk);
    funct3E = 3'b101; SrcAE = 32'd1000; SrcBE = 32'd3; StartE = 1'b1;
    repeat (17) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; StartE = 1'b0;
    #1;
    check("midcalc rst BusyE", {31'b0, BusyE}, 32'd0);
    check("midcalc rst DoneE", {31'b0, DoneE}, 32'd0);
    check("midcalc rst ResultE", ResultE, 32'd0);
    run_op("MUL 3*4 after rst", 3'b000, 32'd3, 32'd4, 32'd12, 33);

    // Abort mid-CALC
    @(negedge clk);
    funct3E = 3'b000; SrcAE = 32'd5; SrcBE = 32'd6; StartE = 1'b1;
    repeat (10) @(negedge clk);
    AbortE = 1'b1;
    #1;
    check("abort BusyE same cycle", {31'b0, BusyE}, 32'd0);
    @(negedge clk);
    AbortE = 1'b0; StartE = 1'b0;
    #1;
    check("abort back to idle", {31'b0, BusyE}, 32'd0);
    repeat (40) @(negedge clk);
    check("abort ResultE kept", ResultE, 32'd12);

    // Abort together with start in IDLE: nothing accepted
    @(negedge clk);
    funct3E = 3'b000; SrcAE = 32'd2; SrcBE = 32'd2; StartE = 1'b1; AbortE = 1'b1;
    #1;
    check("abort+start BusyE", {31'b0, BusyE}, 32'd0);
    @(negedge clk);
    StartE = 1'b0; AbortE = 1'b0;
    #1;
    check("abort+start not accepted", {31'b0, BusyE}, 32'd0);
    repeat (40) @(negedge clk);
    check("abort+start ResultE kept", ResultE, 32'd12);

    check("outstanding results", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
